uart_rx_os: RTL and testbench

- Oversampling UART receiver for the soda-machine UART link.
- Consumes the one-cycle oversample strobe from the baud generator and recovers 8N1 or 8E1/8O1 frames from the asynchronous rx line.
- Presents each received byte with a one-cycle valid pulse to the command/display logic.
- Reports framing and parity errors.

---
 rtl/uart_rx_os_if.sv | 25 ++
 rtl/uart_rx_os.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_os.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: serial-side inputs and byte-side outputs of the oversampling UART receiver.
// Inputs:  s_tick (oversample strobe), rx (raw serial line), parity_en/parity_odd (frame format).
// Outputs: data (last good byte), rx_valid/parity_err/frame_err (one-clk pulses), busy (frame in progress).
// master = driver of the line and consumer of bytes; slave = the receiver itself.
interface uart_rx_os_if;
   logic       s_tick;
   logic       rx;
   logic       parity_en;
   logic       parity_odd;
   logic [7:0] data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport master (
      output s_tick, rx, parity_en, parity_odd,
      input  data, rx_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  s_tick, rx, parity_en, parity_odd,
      output data, rx_valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1 / 8E1 / 8O1 UART receiver, all outputs registered.
// Latency: (OS=16, tick every clk) start confirmed 10 clk after rx falls, byte out 154 clk (170 with parity).
// Backpressure: none; no receive buffer, each good frame overwrites data and pulses rx_valid for one clk.
// Ports: clk, n_rst (async active-low), bus (slave modport of uart_rx_os_if):
//    s_tick/rx/parity_en/parity_odd in; data/rx_valid/parity_err/frame_err/busy out.
// OS must be even and >= 4; CW must satisfy 2**CW >= OS.
module uart_rx_os #(
   parameter int OS = 16,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          n_rst,
   uart_rx_os_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } state_t;

   // Mid-bit sample points: half a bit into the start bit, then one full bit apart.
   localparam logic [CW-1:0] HALF = CW'(OS / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OS - 1);

   state_t        state;
   logic          sync1;
   logic          rx_s;
   logic [CW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          pbit;
   logic          pen_l;
   logic          podd_l;
   logic [7:0]    data_r;
   logic          valid_r;
   logic          perr_r;
   logic          ferr_r;
   logic          busy_r;

   // Two-flop synchronizer; resets to the idle (high) line level so that
   // leaving reset never looks like a start edge.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= bus.rx;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         pbit     <= 1'b0;
         pen_l    <= 1'b0;
         podd_l   <= 1'b0;
         data_r   <= '0;
         valid_r  <= 1'b0;
         perr_r   <= 1'b0;
         ferr_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         // Status outputs are single-cycle pulses.
         valid_r <= 1'b0;
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;

         case (state)
            IDLE: begin
               // Start edge is taken immediately, not on a tick, so the
               // half-bit count starts as close to the edge as possible.
               if (!rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
                  busy_r   <= 1'b1;
               end
            end

            START: begin
               if (bus.s_tick) begin
                  if (tick_cnt == HALF) begin
                     if (!rx_s) begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        // Frame format is frozen for the rest of this frame.
                        pen_l    <= bus.parity_en;
                        podd_l   <= bus.parity_odd;
                     end else begin
                        // Line went back high before mid start bit: noise.
                        state  <= IDLE;
                        busy_r <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            DATA: begin
               if (bus.s_tick) begin
                  if (tick_cnt == LAST) begin
                     tick_cnt <= '0;
                     // LSB arrives first, so shift right and enter at the MSB.
                     shreg    <= {rx_s, shreg[7:1]};
                     if (bit_cnt == 3'd7) begin
                        state <= pen_l ? PARITY : STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            PARITY: begin
               if (bus.s_tick) begin
                  if (tick_cnt == LAST) begin
                     tick_cnt <= '0;
                     pbit     <= rx_s;
                     state    <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            STOP: begin
               if (bus.s_tick) begin
                  if (tick_cnt == LAST) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        // Byte is delivered even with a parity mismatch.
                        data_r  <= shreg;
                        valid_r <= 1'b1;
                        perr_r  <= pen_l & (pbit != ((^shreg) ^ podd_l));
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                     end else begin
                        // Low stop bit: report once, then park until the
                        // line is released so a break gives a single error.
                        ferr_r <= 1'b1;
                        state  <= WAIT_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            WAIT_IDLE: begin
               if (rx_s) begin
                  state  <= IDLE;
                  busy_r <= 1'b0;
               end
            end

            default: begin
               state  <= IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data       = data_r;
   assign bus.rx_valid   = valid_r;
   assign bus.parity_err = perr_r;
   assign bus.frame_err  = ferr_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os (OS=16).
// Table of frames with hand-computed outcomes, plus hand-written sequences for
// exact latency, start glitch, break, back-to-back frames and mid-frame reset.
module tb_uart_rx_os;

   localparam int OS = 16;

   logic clk;
   logic n_rst;
   uart_rx_os_if bus ();

   uart_rx_os #(.OS(OS), .CW(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_div = 1;

   // Pulse counters kept by the monitor; the main thread takes snapshots.
   int         n_valid = 0;
   int         n_perr  = 0;
   int         n_ferr  = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;

   typedef struct {
      logic [7:0] d;
      bit         pen;
      bit         podd;
      bit         pb;
      bit         stop_v;
      bit         flip;
      int         exp_valid;
      logic [7:0] exp_data;
      int         exp_perr;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance n clocks and land 1 time unit after the last rising edge.
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One serial frame; each bit lasts OS ticks of the current tick divider.
   task automatic send_frame(input logic [7:0] d, input bit pen, input bit pb,
                             input bit stop_v, input bit flip);
      int bl;
      bl = OS * tick_div;
      bus.rx = 1'b0;
      hold(bl);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         if (flip && i == 4) begin
            bus.parity_en  = ~bus.parity_en;
            bus.parity_odd = ~bus.parity_odd;
         end
         hold(bl);
      end
      if (pen) begin
         bus.rx = pb;
         hold(bl);
      end
      bus.rx = stop_v;
      hold(bl);
   endtask

   // Frame with cycle-exact checks; edge 0 is the first edge sampling rx low.
   task automatic frame_latency(input string tag, input logic [7:0] d, input bit pen,
                                input bit podd, input bit pb, input int n_edge,
                                input bit exp_perr);
      bus.parity_en  = pen;
      bus.parity_odd = podd;
      fork
         send_frame(d, pen, pb, 1'b1, 1'b0);
         begin
            hold(1);
            hold(1);
            check({tag, " busy@1"}, 32'(bus.busy), 32'd0);
            hold(1);
            check({tag, " busy@2"}, 32'(bus.busy), 32'd1);
            hold(n_edge - 3);
            check({tag, " valid@n-1"}, 32'(bus.rx_valid), 32'd0);
            check({tag, " busy@n-1"}, 32'(bus.busy), 32'd1);
            hold(1);
            check({tag, " valid@n"}, 32'(bus.rx_valid), 32'd1);
            check({tag, " data@n"}, 32'(bus.data), 32'(d));
            check({tag, " perr@n"}, 32'(bus.parity_err), 32'(exp_perr));
            check({tag, " ferr@n"}, 32'(bus.frame_err), 32'd0);
            check({tag, " busy@n"}, 32'(bus.busy), 32'd0);
            hold(1);
            check({tag, " valid@n+1"}, 32'(bus.rx_valid), 32'd0);
            check({tag, " perr@n+1"}, 32'(bus.parity_err), 32'd0);
         end
      join
      hold(10);
   endtask

   // Oversample strobe: one clk wide, every tick_div clocks.
   initial begin
      int cnt;
      cnt = 0;
      bus.s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (cnt >= tick_div - 1) begin
            cnt = 0;
            bus.s_tick = 1'b1;
         end else begin
            cnt++;
            bus.s_tick = 1'b0;
         end
      end
   end

   // Output monitor, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.rx_valid === 1'b1) begin
            n_valid++;
            prev_data = last_data;
            last_data = bus.data;
            if (bus.parity_err === 1'b1) n_perr++;
         end else if (bus.parity_err === 1'b1) begin
            n_perr += 100;
         end
         if (bus.frame_err === 1'b1) n_ferr++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, p0, f0;

      // Expected parity bit = XOR(data) ^ parity_odd.
      //  0xA7: 5 ones -> even needs 1, odd needs 0.  0x00: even 0, odd 1.
      //  0xC3: 4 ones -> odd needs 1.                0x5A: 4 ones -> even needs 0.
      //          d      pen podd pb stop flip  val data   perr ferr
      vecs[0] = '{8'h55, 0, 0, 0, 1, 0, 1, 8'h55, 0, 0};
      vecs[1] = '{8'hA7, 1, 0, 1, 1, 0, 1, 8'hA7, 0, 0};
      vecs[2] = '{8'hA7, 1, 0, 0, 1, 0, 1, 8'hA7, 1, 0};
      vecs[3] = '{8'hA7, 1, 1, 0, 1, 0, 1, 8'hA7, 0, 0};
      vecs[4] = '{8'h00, 1, 1, 0, 1, 0, 1, 8'h00, 1, 0};
      vecs[5] = '{8'h00, 1, 0, 0, 1, 0, 1, 8'h00, 0, 0};
      vecs[6] = '{8'hFF, 0, 0, 0, 1, 0, 1, 8'hFF, 0, 0};
      vecs[7] = '{8'h12, 0, 0, 0, 0, 0, 0, 8'hFF, 0, 1};
      vecs[8] = '{8'hC3, 1, 1, 1, 1, 0, 1, 8'hC3, 0, 0};
      vecs[9] = '{8'h5A, 1, 0, 0, 1, 1, 1, 8'h5A, 0, 0};

      bus.rx = 1'b1;
      bus.parity_en = 1'b0;
      bus.parity_odd = 1'b0;
      n_rst = 1'b0;
      hold(3);
      check("reset data", 32'(bus.data), 32'h00);
      check("reset valid", 32'(bus.rx_valid), 32'd0);
      check("reset perr", 32'(bus.parity_err), 32'd0);
      check("reset ferr", 32'(bus.frame_err), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      n_rst = 1'b1;
      hold(5);
      check("idle busy", 32'(bus.busy), 32'd0);

      // Exact latency.
      frame_latency("lat55", 8'h55, 1'b0, 1'b0, 1'b0, 154, 1'b0);
      frame_latency("latA7ok", 8'hA7, 1'b1, 1'b0, 1'b1, 170, 1'b0);
      frame_latency("latA7bad", 8'hA7, 1'b1, 1'b0, 1'b0, 170, 1'b1);

      // Table of frames.
      for (int i = 0; i < 10; i++) begin
         bus.parity_en  = vecs[i].pen;
         bus.parity_odd = vecs[i].podd;
         v0 = n_valid; p0 = n_perr; f0 = n_ferr;
         send_frame(vecs[i].d, vecs[i].pen, vecs[i].pb, vecs[i].stop_v, vecs[i].flip);
         bus.rx = 1'b1;
         hold(20);
         check($sformatf("vec%0d valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d data", i), 32'(bus.data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d perr", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
         check($sformatf("vec%0d ferr", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
      end
      bus.parity_en = 1'b0;
      bus.parity_odd = 1'b0;

      // Start glitch: 5 clk low, rejected at mid start bit (edge 10).
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      bus.rx = 1'b0;
      hold(1);
      hold(4);
      bus.rx = 1'b1;
      hold(5);
      check("glitch busy@9", 32'(bus.busy), 32'd1);
      hold(1);
      check("glitch busy@10", 32'(bus.busy), 32'd0);
      hold(20);
      check("glitch pulses", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 32'd0);
      check("glitch data", 32'(bus.data), 32'h5A);

      // Break: low stop bit then line held low; one frame_err, busy until line returns.
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      hold(100);
      check("break busy low", 32'(bus.busy), 32'd1);
      bus.rx = 1'b1;
      hold(1);
      hold(1);
      check("break busy@1", 32'(bus.busy), 32'd1);
      hold(1);
      check("break busy@2", 32'(bus.busy), 32'd0);
      check("break ferr count", 32'(n_ferr - f0), 32'd1);
      check("break valid count", 32'(n_valid - v0), 32'd0);
      check("break data kept", 32'(bus.data), 32'h5A);
      hold(10);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(20);
      check("after break data", 32'(bus.data), 32'h81);
      check("after break valid", 32'(n_valid - v0), 32'd1);

      // Back-to-back frames, tick every 3rd clk.
      tick_div = 3;
      hold(6);
      v0 = n_valid; p0 = n_perr; f0 = n_ferr;
      send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(60);
      check("b2b valid count", 32'(n_valid - v0), 32'd2);
      check("b2b first data", 32'(prev_data), 32'h00);
      check("b2b second data", 32'(last_data), 32'hFF);
      check("b2b errors", 32'((n_perr - p0) + (n_ferr - f0)), 32'd0);
      tick_div = 1;
      hold(6);

      // Reset in the middle of data bit 4 of 0x96.
      v0 = n_valid;
      bus.rx = 1'b0;
      hold(OS);
      for (int i = 0; i < 4; i++) begin
         bus.rx = (8'h96 >> i) & 8'h01;
         hold(OS);
      end
      bus.rx = 1'b1;
      hold(OS / 2);
      check("pre-rst busy", 32'(bus.busy), 32'd1);
      n_rst = 1'b0;
      #1;
      check("mid-rst data", 32'(bus.data), 32'h00);
      check("mid-rst busy", 32'(bus.busy), 32'd0);
      check("mid-rst valid", 32'(bus.rx_valid), 32'd0);
      hold(3);
      n_rst = 1'b1;
      hold(200);
      check("post-rst no pulse", 32'(n_valid - v0), 32'd0);
      check("post-rst data", 32'(bus.data), 32'h00);
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
      hold(20);
      check("post-rst frame data", 32'(bus.data), 32'h96);
      check("post-rst frame valid", 32'(n_valid - v0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
